// File: rtl/fnn_ctrl_pkg.sv
// Shared control types for the fully connected layer sequencers.
// Each layer's sequencer imports this package.
package fnn_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        DRAIN,
        WAIT_OUT,
        DONE
    } seq_state_t;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_out_capture.sv
// Per-neuron result register bank with a completion mask.
// Flags a neuron that reports twice within one layer pass.
module layer_out_capture
    import fnn_ctrl_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              enable,
    input  logic [NUM_NEURONS-1:0]            outvalid,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] data_out,
    output logic                              all_done,
    output logic                              dup_err
);

    logic [NUM_NEURONS-1:0] mask_q;
    logic [NUM_NEURONS-1:0] hit;

    assign hit      = enable ? outvalid : '0;
    // Neurons finishing in this very cycle already count toward completion.
    assign all_done = &(mask_q | hit);
    assign dup_err  = |(mask_q & hit);

    // NOTE: the result bank is reset along with the mask, so layer_out reads 0
    // after reset; clear only restarts the mask and the last result stays visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q   <= '0;
            data_out <= '0;
        end else begin
            if (clear) begin
                mask_q <= '0;
            end else begin
                mask_q <= mask_q | hit;
            end
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (hit[i]) begin
                    data_out[i*DATA_WIDTH +: DATA_WIDTH] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Streams one layer's input vector to its neuron array and collects
// every neuron's activation into layer_out before handing off.
module layer_sequencer
    import fnn_ctrl_pkg::*;
#(
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 in_rd_en,
    output logic [addr_width(NUM_INPUTS)-1:0]    in_rd_addr,
    input  logic [DATA_WIDTH-1:0]                in_rd_data,
    output logic [DATA_WIDTH-1:0]                neuron_in,
    output logic                                 neuron_in_valid,
    input  logic [NUM_NEURONS-1:0]               neuron_outvalid,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0]    neuron_out,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0]    layer_out,
    output logic                                 layer_out_valid,
    output logic                                 busy,
    output logic                                 err
);

    localparam int AW = addr_width(NUM_INPUTS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_INPUTS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    seq_state_t     state_q, state_d;
    logic [AW-1:0]  addr_q;
    logic [TW-1:0]  tmo_q;
    logic           err_q;
    logic           valid_q;
    logic           accept;
    logic           stream_last;
    logic           timeout_hit;
    logic           all_done;
    logic           dup_err;
    logic           cap_en;

    assign accept      = (state_q == IDLE) && start;
    assign stream_last = (state_q == STREAM) && (addr_q == LAST_ADDR);
    assign timeout_hit = (state_q == WAIT_OUT) && !all_done && (tmo_q == TMO_LAST);
    assign cap_en      = (state_q != IDLE);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d         = state_q;
        in_rd_en        = 1'b0;
        layer_out_valid = 1'b0;
        busy            = (state_q != IDLE);
        case (state_q)
            IDLE:     if (start) state_d = STREAM;
            STREAM: begin
                in_rd_en = 1'b1;
                if (stream_last) state_d = DRAIN;
            end
            DRAIN:    state_d = WAIT_OUT;
            WAIT_OUT: begin
                if (all_done)         state_d = DONE;
                else if (timeout_hit) state_d = IDLE;
            end
            DONE: begin
                layer_out_valid = 1'b1;
                state_d         = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= in_rd_en;
            // The address stops at LAST_ADDR and is cleared, so it never wraps.
            if (state_q == STREAM && !stream_last) begin
                addr_q <= addr_q + AW'(1);
            end else begin
                addr_q <= '0;
            end
            if (state_q == WAIT_OUT) begin
                tmo_q <= tmo_q + TW'(1);
            end else begin
                tmo_q <= '0;
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (dup_err || timeout_hit
                         || (state_q == STREAM && |neuron_outvalid)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign in_rd_addr      = addr_q;
    assign neuron_in_valid = valid_q;
    // The buffer registers each read, so its data lines up with valid_q.
    assign neuron_in       = valid_q ? in_rd_data : '0;
    assign err             = err_q;

    layer_out_capture #(
        .NUM_NEURONS (NUM_NEURONS),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_capture (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .enable   (cap_en),
        .outvalid (neuron_outvalid),
        .data_in  (neuron_out),
        .data_out (layer_out),
        .all_done (all_done),
        .dup_err  (dup_err)
    );

endmodule
